// File: rtl/green_mask_sequencer_pkg.sv
// Shared frame geometry, green threshold defaults, config addresses and FSM states
// for the green-screen mask sequencer.
package green_mask_sequencer_pkg;

  localparam int FRAME_LENGTH = 4;
  localparam int FRAME_WIDTH  = 8;

  localparam logic [7:0] LOWER_GREEN_ONE   = 8'd0;
  localparam logic [7:0] UPPER_GREEN_ONE   = 8'd100;
  localparam logic [7:0] LOWER_GREEN_TWO   = 8'd150;
  localparam logic [7:0] UPPER_GREEN_TWO   = 8'd255;
  localparam logic [7:0] LOWER_GREEN_THREE = 8'd0;
  localparam logic [7:0] UPPER_GREEN_THREE = 8'd100;

  localparam logic [2:0] CFG_LO0 = 3'd0;
  localparam logic [2:0] CFG_HI0 = 3'd1;
  localparam logic [2:0] CFG_LO1 = 3'd2;
  localparam logic [2:0] CFG_HI1 = 3'd3;
  localparam logic [2:0] CFG_LO2 = 3'd4;
  localparam logic [2:0] CFG_HI2 = 3'd5;

  typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;

endpackage

// File: rtl/green_mask_sequencer_pixel_test.sv
// Combinational three-channel inclusive range test; fg_o is 1 for any pixel
// that falls outside the green window on at least one channel.
module green_pixel_test
  import green_mask_sequencer_pkg::*;
(
  input  logic [2:0][7:0] pix_i,
  input  logic [2:0][7:0] lo_i,
  input  logic [2:0][7:0] hi_i,
  output logic            fg_o
);

  logic [2:0] inRange;

  // An inverted window (lo > hi) can never be satisfied, so it forces foreground.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      inRange[k] = (pix_i[k] >= lo_i[k]) && (pix_i[k] <= hi_i[k]);
    end
  end

  assign fg_o = ~&inRange;

endmodule

// File: rtl/green_mask_sequencer.sv
// Frame sequencer: tests streamed pixels against programmable green thresholds and
// emits one foreground-mask row at a time. Optional bounding box via GREEN_MASK_BBOX_EN.
module green_mask_sequencer
  import green_mask_sequencer_pkg::*;
#(
  parameter int LENGTH = FRAME_LENGTH,
  parameter int WIDTH  = FRAME_WIDTH,
  parameter int CW     = $clog2(LENGTH*WIDTH+1)
) (
  input  logic                      clk,
  input  logic                      rst_in,
  input  logic                      start_in,
  input  logic                      cfg_we_in,
  input  logic [2:0]                cfg_addr_in,
  input  logic [7:0]                cfg_data_in,
  input  logic                      pix_valid_in,
  input  logic [2:0][7:0]           pix_in,
  output logic                      pix_ready_out,
  output logic                      row_valid_out,
  input  logic                      row_ready_in,
  output logic [$clog2(LENGTH)-1:0] row_idx_out,
  output logic [WIDTH-1:0]          row_mask_out,
  output logic                      busy_out,
  output logic                      done_out,
  output logic [CW-1:0]             fg_count_out
`ifdef GREEN_MASK_BBOX_EN
  ,
  output logic                      bbox_valid_out,
  output logic [$clog2(LENGTH)-1:0] bbox_rmin_out,
  output logic [$clog2(LENGTH)-1:0] bbox_rmax_out,
  output logic [$clog2(WIDTH)-1:0]  bbox_cmin_out,
  output logic [$clog2(WIDTH)-1:0]  bbox_cmax_out
`endif
);

  localparam int RW  = $clog2(LENGTH);
  localparam int CLW = $clog2(WIDTH);
  localparam logic [RW-1:0]  LAST_ROW = RW'(LENGTH-1);
  localparam logic [CLW-1:0] LAST_COL = CLW'(WIDTH-1);

  state_t          state_q;
  logic [CLW-1:0]  col_q;
  logic [RW-1:0]   row_q;
  logic [WIDTH-1:0] mask_q;
  logic [CW-1:0]   fg_count_q;
  logic [2:0][7:0] lo_q;
  logic [2:0][7:0] hi_q;
  logic            pix_ready_q;
  logic            row_valid_q;
  logic            busy_q;
  logic            done_q;
  logic            pix_fg;

`ifdef GREEN_MASK_BBOX_EN
  logic            bbox_valid_q;
  logic [RW-1:0]   bbox_rmin_q;
  logic [RW-1:0]   bbox_rmax_q;
  logic [CLW-1:0]  bbox_cmin_q;
  logic [CLW-1:0]  bbox_cmax_q;
`endif

  green_pixel_test u_pixel_test (
    .pix_i (pix_in),
    .lo_i  (lo_q),
    .hi_i  (hi_q),
    .fg_o  (pix_fg)
  );

  // Handshake flags are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      mask_q      <= '0;
      fg_count_q  <= '0;
      lo_q        <= {LOWER_GREEN_THREE, LOWER_GREEN_TWO, LOWER_GREEN_ONE};
      hi_q        <= {UPPER_GREEN_THREE, UPPER_GREEN_TWO, UPPER_GREEN_ONE};
      pix_ready_q <= 1'b0;
      row_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef GREEN_MASK_BBOX_EN
      bbox_valid_q <= 1'b0;
      bbox_rmin_q  <= LAST_ROW;
      bbox_rmax_q  <= '0;
      bbox_cmin_q  <= LAST_COL;
      bbox_cmax_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Thresholds are only writable here, which freezes them for a whole frame.
          if (cfg_we_in) begin
            case (cfg_addr_in)
              CFG_LO0: lo_q[0] <= cfg_data_in;
              CFG_HI0: hi_q[0] <= cfg_data_in;
              CFG_LO1: lo_q[1] <= cfg_data_in;
              CFG_HI1: hi_q[1] <= cfg_data_in;
              CFG_LO2: lo_q[2] <= cfg_data_in;
              CFG_HI2: hi_q[2] <= cfg_data_in;
              default: ;
            endcase
          end
          if (start_in) begin
            state_q     <= FILL;
            col_q       <= '0;
            row_q       <= '0;
            mask_q      <= '0;
            fg_count_q  <= '0;
            pix_ready_q <= 1'b1;
            busy_q      <= 1'b1;
`ifdef GREEN_MASK_BBOX_EN
            bbox_valid_q <= 1'b0;
            bbox_rmin_q  <= LAST_ROW;
            bbox_rmax_q  <= '0;
            bbox_cmin_q  <= LAST_COL;
            bbox_cmax_q  <= '0;
`endif
          end
        end
        FILL: begin
          if (pix_valid_in) begin
            mask_q[col_q] <= pix_fg;
            if (pix_fg) begin
              fg_count_q <= fg_count_q + CW'(1);
`ifdef GREEN_MASK_BBOX_EN
              bbox_valid_q <= 1'b1;
              if (row_q < bbox_rmin_q) bbox_rmin_q <= row_q;
              if (row_q > bbox_rmax_q) bbox_rmax_q <= row_q;
              if (col_q < bbox_cmin_q) bbox_cmin_q <= col_q;
              if (col_q > bbox_cmax_q) bbox_cmax_q <= col_q;
`endif
            end
            if (col_q == LAST_COL) begin
              state_q     <= EMIT;
              pix_ready_q <= 1'b0;
              row_valid_q <= 1'b1;
            end else begin
              col_q <= col_q + CLW'(1);
            end
          end
        end
        EMIT: begin
          if (row_ready_in) begin
            row_valid_q <= 1'b0;
            if (row_q == LAST_ROW) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= FILL;
              row_q       <= row_q + RW'(1);
              col_q       <= '0;
              mask_q      <= '0;
              pix_ready_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pix_ready_out = pix_ready_q;
  assign row_valid_out = row_valid_q;
  assign row_idx_out   = row_q;
  assign row_mask_out  = mask_q;
  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign fg_count_out  = fg_count_q;

`ifdef GREEN_MASK_BBOX_EN
  assign bbox_valid_out = bbox_valid_q;
  assign bbox_rmin_out  = bbox_rmin_q;
  assign bbox_rmax_out  = bbox_rmax_q;
  assign bbox_cmin_out  = bbox_cmin_q;
  assign bbox_cmax_out  = bbox_cmax_q;
`endif

endmodule

// File: tb/tb_green_mask_sequencer.sv
// Directed self-checking bench for green_mask_sequencer (4x8 frame); bbox checks
// are compiled in when GREEN_MASK_BBOX_EN is defined.
module tb_green_mask_sequencer;

  localparam int L  = 4;
  localparam int W  = 8;
  localparam int CW = $clog2(L*W+1);
  localparam logic [23:0] GREEN = {8'd30, 8'd200, 8'd20};

  logic            clk = 1'b0;
  logic            rst_in;
  logic            start_in;
  logic            cfg_we_in;
  logic [2:0]      cfg_addr_in;
  logic [7:0]      cfg_data_in;
  logic            pix_valid_in;
  logic [2:0][7:0] pix_in;
  logic            pix_ready_out;
  logic            row_valid_out;
  logic            row_ready_in;
  logic [1:0]      row_idx_out;
  logic [W-1:0]    row_mask_out;
  logic            busy_out;
  logic            done_out;
  logic [CW-1:0]   fg_count_out;
`ifdef GREEN_MASK_BBOX_EN
  logic            bbox_valid_out;
  logic [1:0]      bbox_rmin_out;
  logic [1:0]      bbox_rmax_out;
  logic [2:0]      bbox_cmin_out;
  logic [2:0]      bbox_cmax_out;
`endif

  int testCount = 0;
  int failCount = 0;
  int cyc = 0;
  int rowsSeen, pixIdx, doneCycle, stallCount;
  bit doneSeen;
  logic [23:0]  frame [L*W];
  logic [7:0]   curLo [3];
  logic [7:0]   curHi [3];
  logic [W-1:0] gotMask [L];
  logic [1:0]   gotIdx [L];

  always #5 clk = ~clk;

  green_mask_sequencer #(.LENGTH(L), .WIDTH(W), .CW(CW)) dut (
    .clk           (clk),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .cfg_we_in     (cfg_we_in),
    .cfg_addr_in   (cfg_addr_in),
    .cfg_data_in   (cfg_data_in),
    .pix_valid_in  (pix_valid_in),
    .pix_in        (pix_in),
    .pix_ready_out (pix_ready_out),
    .row_valid_out (row_valid_out),
    .row_ready_in  (row_ready_in),
    .row_idx_out   (row_idx_out),
    .row_mask_out  (row_mask_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .fg_count_out  (fg_count_out)
`ifdef GREEN_MASK_BBOX_EN
    ,
    .bbox_valid_out (bbox_valid_out),
    .bbox_rmin_out  (bbox_rmin_out),
    .bbox_rmax_out  (bbox_rmax_out),
    .bbox_cmin_out  (bbox_cmin_out),
    .bbox_cmax_out  (bbox_cmax_out)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input logic s, input logic we, input logic [2:0] a, input logic [7:0] d);
    start_in    = s;
    cfg_we_in   = we;
    cfg_addr_in = a;
    cfg_data_in = d;
  endtask

  task automatic setDefaults();
    curLo[0] = 8'd0;   curHi[0] = 8'd100;
    curLo[1] = 8'd150; curHi[1] = 8'd255;
    curLo[2] = 8'd0;   curHi[2] = 8'd100;
  endtask

  function automatic bit isFg(input logic [23:0] p);
    for (int k = 0; k < 3; k++) begin
      if (p[8*k +: 8] < curLo[k] || p[8*k +: 8] > curHi[k]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] expMask(input int r);
    logic [W-1:0] m = '0;
    for (int c = 0; c < W; c++) m[c] = isFg(frame[r*W + c]);
    return m;
  endfunction

  function automatic int expCount();
    int n = 0;
    for (int i = 0; i < L*W; i++) n += int'(isFg(frame[i]));
    return n;
  endfunction

  task automatic fillPattern();
    for (int i = 0; i < L*W; i++) frame[i] = {8'(i*53), 8'(255 - i*11), 8'(i*37)};
    frame[0] = {8'd0,   8'd150, 8'd100};
    frame[1] = {8'd0,   8'd150, 8'd101};
    frame[2] = {8'd0,   8'd149, 8'd0};
    frame[3] = {8'd100, 8'd255, 8'd0};
  endtask

  task automatic runFrame(input bit gaps, input bit stall, input bit midCfg, input int abortAt,
                          input logic we, input logic [2:0] a, input logic [7:0] d);
    logic [W-1:0] stallMask;
    stallMask = '0;
    rowsSeen = 0; pixIdx = 0; doneSeen = 0; doneCycle = -1; stallCount = 0;
    applyStimulus(1'b1, we, a, d);
    if (we && a < 3'd6) begin
      if (a[0]) curHi[a >> 1] = d;
      else curLo[a >> 1] = d;
    end
    tick();
    cyc = 1;
    applyStimulus(1'b0, 1'b0, 3'd0, 8'd0);
    checkOutput("ready_after_start", 32'(pix_ready_out), 32'd1);
    checkOutput("busy_after_start", 32'(busy_out), 32'd1);
    while (!doneSeen && cyc < 2000) begin
      if (abortAt > 0 && pixIdx == abortAt) break;
      pix_in = frame[pixIdx < L*W ? pixIdx : 0];
      pix_valid_in = (pixIdx < L*W) && (!gaps || $urandom_range(0, 3) != 0);
      row_ready_in = 1'b1;
      if (stall && rowsSeen == 0 && row_valid_out && stallCount < 7) begin
        row_ready_in = 1'b0;
        checkOutput("stall_ready_low", 32'(pix_ready_out), 32'd0);
        if (stallCount == 0) stallMask = row_mask_out;
        else checkOutput("stall_mask_stable", 32'(row_mask_out), 32'(stallMask));
        stallCount++;
      end
      if (midCfg && cyc == 5) applyStimulus(1'b1, 1'b1, 3'd0, 8'd255);
      else if (midCfg) applyStimulus(1'b0, 1'b0, 3'd0, 8'd0);
      if (done_out) begin
        doneSeen = 1'b1;
        doneCycle = cyc;
      end
      if (row_valid_out && row_ready_in && rowsSeen < L) begin
        gotMask[rowsSeen] = row_mask_out;
        gotIdx[rowsSeen] = row_idx_out;
        rowsSeen++;
      end
      if (pix_valid_in && pix_ready_out) pixIdx++;
      if (!doneSeen) tick();
    end
    pix_valid_in = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 8'd0);
  endtask

  task automatic checkFrame(input bit timed);
    checkOutput("done_seen", 32'(doneSeen), 32'd1);
    checkOutput("rows_seen", 32'(rowsSeen), 32'(L));
    checkOutput("pixels_accepted", 32'(pixIdx), 32'(L*W));
    for (int r = 0; r < L; r++) begin
      checkOutput($sformatf("row_idx%0d", r), 32'(gotIdx[r]), 32'(r));
      checkOutput($sformatf("row_mask%0d", r), 32'(gotMask[r]), 32'(expMask(r)));
    end
    checkOutput("fg_count", 32'(fg_count_out), 32'(expCount()));
    if (timed) checkOutput("done_cycle", 32'(doneCycle), 32'(L*(W+1)+1));
    tick();
    checkOutput("done_pulse_width", 32'(done_out), 32'd0);
    checkOutput("busy_after_done", 32'(busy_out), 32'd0);
    checkOutput("fg_count_hold", 32'(fg_count_out), 32'(expCount()));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_pix_ready"}, 32'(pix_ready_out), 32'd0);
    checkOutput({tag, "_row_valid"}, 32'(row_valid_out), 32'd0);
    checkOutput({tag, "_done"}, 32'(done_out), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy_out), 32'd0);
    checkOutput({tag, "_row_idx"}, 32'(row_idx_out), 32'd0);
    checkOutput({tag, "_row_mask"}, 32'(row_mask_out), 32'd0);
    checkOutput({tag, "_fg_count"}, 32'(fg_count_out), 32'd0);
`ifdef GREEN_MASK_BBOX_EN
    checkOutput({tag, "_bbox_valid"}, 32'(bbox_valid_out), 32'd0);
    checkOutput({tag, "_bbox_rmin"}, 32'(bbox_rmin_out), 32'(L-1));
    checkOutput({tag, "_bbox_cmin"}, 32'(bbox_cmin_out), 32'(W-1));
    checkOutput({tag, "_bbox_rmax"}, 32'(bbox_rmax_out), 32'd0);
    checkOutput({tag, "_bbox_cmax"}, 32'(bbox_cmax_out), 32'd0);
`endif
  endtask

  initial begin
    rst_in = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'd0, 8'd0);
    pix_valid_in = 1'b0;
    pix_in = '0;
    row_ready_in = 1'b0;
    setDefaults();
    tick();
    tick();
    checkResetOutputs("reset");
    rst_in = 1'b0;
    tick();

    // All-green frame with default thresholds and an always-ready consumer.
    for (int i = 0; i < L*W; i++) frame[i] = GREEN;
    runFrame(1'b0, 1'b0, 1'b0, 0, 1'b0, 3'd0, 8'd0);
    checkFrame(1'b1);
`ifdef GREEN_MASK_BBOX_EN
    checkOutput("green_bbox_valid", 32'(bbox_valid_out), 32'd0);
`endif

    // One magenta pixel at row 2, column 5.
    frame[2*W + 5] = {8'd255, 8'd0, 8'd255};
    runFrame(1'b0, 1'b0, 1'b0, 0, 1'b0, 3'd0, 8'd0);
    checkFrame(1'b1);
    checkOutput("single_row2_mask", 32'(gotMask[2]), 32'h20);
    checkOutput("single_fg_count", 32'(fg_count_out), 32'd1);
`ifdef GREEN_MASK_BBOX_EN
    checkOutput("single_bbox_valid", 32'(bbox_valid_out), 32'd1);
    checkOutput("single_bbox_rmin", 32'(bbox_rmin_out), 32'd2);
    checkOutput("single_bbox_rmax", 32'(bbox_rmax_out), 32'd2);
    checkOutput("single_bbox_cmin", 32'(bbox_cmin_out), 32'd5);
    checkOutput("single_bbox_cmax", 32'(bbox_cmax_out), 32'd5);
`endif

    // Mixed pattern with random valid gaps and a seven-cycle stall on row 0.
    fillPattern();
    runFrame(1'b1, 1'b1, 1'b0, 0, 1'b0, 3'd0, 8'd0);
    checkFrame(1'b0);
    checkOutput("stall_cycles", 32'(stallCount), 32'd7);

    // Config write and start issued mid-frame must be ignored.
    runFrame(1'b0, 1'b0, 1'b1, 0, 1'b0, 3'd0, 8'd0);
    checkFrame(1'b1);

    // Inverted ch0 window: lo0 written alone, hi0 written together with start.
    applyStimulus(1'b0, 1'b1, 3'd0, 8'd200);
    curLo[0] = 8'd200;
    tick();
    applyStimulus(1'b0, 1'b0, 3'd0, 8'd0);
    runFrame(1'b0, 1'b0, 1'b0, 0, 1'b1, 3'd1, 8'd10);
    checkFrame(1'b1);
    checkOutput("inverted_all_fg", 32'(fg_count_out), 32'(L*W));

    // Reset in the middle of row 1, then a clean frame on default thresholds.
    runFrame(1'b0, 1'b0, 1'b0, W + 3, 1'b0, 3'd0, 8'd0);
    checkOutput("pre_reset_fg_count", 32'(fg_count_out), 32'(W + 3));
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    checkResetOutputs("midreset");
    setDefaults();
    tick();
    runFrame(1'b0, 1'b0, 1'b0, 0, 1'b0, 3'd0, 8'd0);
    checkFrame(1'b1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/green_mask_sequencer.md
# green_mask_sequencer

Streaming controller that sequences the green-screen filter for the rock-paper-scissors classifier. It accepts one frame of LENGTH×WIDTH RGB pixels over a valid/ready stream and tests each pixel against six runtime-programmable green thresholds. It assembles one foreground-mask row at a time and hands each completed row to the downstream classifier over a second valid/ready handshake. It reports the frame's total foreground-pixel count on completion.

## Interface
Parameters:
- LENGTH, default from common.svh: frame rows.
- WIDTH, default from common.svh: frame columns.
- CW, default $clog2(LENGTH*WIDTH+1): foreground count width.

Ports:
- clk, input, 1: sole clock; all state updates on posedge.
- rst_in, input, 1: synchronous, active-high reset.
- start_in, input, 1: begin frame; honoured only in IDLE.
- cfg_we_in, input, 1: threshold write strobe; honoured only in IDLE.
- cfg_addr_in, input, 3: threshold select. 0/1 = ch0 lo/hi, 2/3 = ch1 lo/hi, 4/5 = ch2 lo/hi; 6–7 ignored.
- cfg_data_in, input, 8: threshold value.
- pix_valid_in, input, 1: pixel present.
- pix_in, input, [2:0][7:0]: channels 0..2 of the current pixel.
- pix_ready_out, output, 1: pixel accepted when valid&&ready.
- row_valid_out, output, 1: mask row present.
- row_ready_in, input, 1: downstream accepts the row.
- row_idx_out, output, $clog2(LENGTH): index of the presented row.
- row_mask_out, output, WIDTH: bit j = column j; 1 = foreground (not green).
- busy_out, output, 1: high in any state except IDLE.
- done_out, output, 1: one-cycle pulse at frame end.
- fg_count_out, output, CW: foreground pixels in the last or current frame.

## Operation
- States:
  - IDLE: start_in → FILL; clears col, row, mask and fg_count.
  - FILL: accepts pixels in raster order, shifting each mask bit into column col. On the WIDTH-th accept → EMIT.
  - EMIT: holds row_valid_out. On row_ready_in: if row == LENGTH-1 → DONE, else row++, col=0 → FILL.
  - DONE: done_out=1 for one cycle → IDLE.
- Pixel test: a pixel is green iff lo_k ≤ ch_k ≤ hi_k, inclusive, for all k. Green → 0; otherwise → 1 and fg_count++.
- If lo_k > hi_k, no pixel can match: every pixel is foreground.
- pix_ready_out = 1 only in FILL. Fill and emit never overlap, and no pixel is dropped or duplicated.
- row_mask_out and row_idx_out are stable while row_valid_out is high and not yet accepted.
- start_in while busy is ignored. cfg_we_in while busy is ignored; thresholds are frozen for the whole frame.
- fg_count_out holds its value after DONE until the next accepted start_in.
- fg_count cannot overflow, since CW covers LENGTH*WIDTH.

## Timing
- Reset values:
  - state IDLE; pix_ready_out, row_valid_out, done_out, busy_out = 0.
  - row_idx_out, row_mask_out, fg_count_out = 0.
  - Thresholds = LOWER/UPPER_GREEN_ONE/TWO/THREE from common.svh.
- start_in sampled at cycle t → FILL and pix_ready_out=1 at t+1.
- WIDTH-th pixel accepted at t → row_valid_out=1 at t+1, and the mask includes that pixel.
- Row accepted at t → pix_ready_out=1 at t+1 for non-final rows. For the final row, done_out=1 at t+1 and busy_out=0 at t+2.
- Minimum frame time, with no stalls: 1 + LENGTH*(WIDTH+1) + 1 cycles from start_in.
- A threshold write at t takes effect for a frame started at t+1 or later.
- Simultaneous cfg_we_in and start_in in IDLE: the write is performed, and the new frame uses the written value.
- rst_in mid-frame: IDLE next cycle, all outputs at reset values, thresholds restored to defaults.

## Configuration
- GREEN_MASK_BBOX_EN defined:
  - Adds outputs bbox_valid_out (1), bbox_rmin/rmax_out ($clog2(LENGTH)) and bbox_cmin/cmax_out ($clog2(WIDTH)).
  - These give the foreground bounding box and are updated per accepted pixel.
  - All are valid with done_out and held until the next start. bbox_valid_out=0 if fg_count==0.
  - Reset: rmin=LENGTH-1, cmin=WIDTH-1, rmax=cmax=0, valid=0.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

## Structure
- common.svh: LENGTH, WIDTH, green threshold defaults, cfg address localparams (CFG_LO0..CFG_HI2), and the state enum typedef (IDLE/FILL/EMIT/DONE).
- Sub-module green_pixel_test: combinational 3-channel inclusive range compare → fg bit. It is instantiated once in the sequencer.

## Test plan
- Default thresholds; all-green frame; row_ready_in tied 1:
  - LENGTH rows of mask 0, row_idx 0..LENGTH-1.
  - fg_count=0; done_out exactly one pulse at cycle 1+LENGTH*(WIDTH+1)+1.
- Single pixel (255,0,255) at row 2, col 5, rest green:
  - Row 2 mask has only bit 5 set; fg_count=1.
  - With _EN: bbox 2..2 / 5..5, bbox_valid_out=1.
- Random pix_valid_in gaps plus row_ready_in held low 7 cycles on row 0:
  - pix_ready_out low throughout the stall.
  - row_mask_out stable; no pixel lost; count matches reference model.
- Write lo0=200, hi0=10 in IDLE, then a frame: all mask bits 1, fg_count=LENGTH*WIDTH.
- cfg_we_in and start_in issued mid-frame: no effect on thresholds, state or count.
- rst_in asserted mid row 1: next cycle all outputs at reset values. A following full frame completes correctly with default thresholds.
